mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (port 0) and load/store data (port 1).
- Drives the select of the existing 32-bit 2:1 address/data mux in front of memory, and sequences each access with a req/ready handshake.
- Data has priority over fetch, with a bounded-streak rule so fetch is never starved.
- Sits between the IF/MEM pipeline stages and the memory interface.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory port and mem_port_arbiter.
// Handshake: req is a level held (with its address/data stable) until the one-cycle ack;
// mem_req/mem_* are held stable until mem_ready, which completes the access in that cycle.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] rdata;
  logic        mem_sel;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_ack, d_ack, rdata, mem_sel, mem_req, mem_addr, mem_we, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_ack, d_ack, rdata, mem_sel, mem_req, mem_addr, mem_we, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port 0) and load/store data (port 1).
// Define ARB_TIMEOUT_EN to abort accesses that see no mem_ready within TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int STREAK_W   = 3,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [STREAK_W-1:0] streak;
  logic                sel_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                streak_full;
  logic                grant_d;
  logic                grant_f;
  logic                timeout_hit;

  // Data wins unless a waiting fetch has already been passed over MAX_STREAK times.
  assign streak_full = (streak == STREAK_W'(MAX_STREAK));
  assign grant_d     = (state == IDLE) && bus.d_req && !(bus.if_req && streak_full);
  assign grant_f     = (state == IDLE) && !grant_d && bus.if_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_f) state_nxt = BUSY;
      BUSY:    if (bus.mem_ready || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_sel still names the granted port while in DONE, so it steers the ack.
  always_comb begin
    bus.mem_req = (state == BUSY);
    bus.if_ack  = (state == DONE) && !sel_q;
    bus.d_ack   = (state == DONE) && sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      streak  <= '0;
    end else begin
      if (grant_d) begin
        sel_q   <= 1'b1;
        we_q    <= bus.d_we;
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        if (bus.if_req) streak <= streak_full ? streak : streak + STREAK_W'(1);
        else            streak <= '0;
      end else if (grant_f) begin
        sel_q   <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= bus.if_addr;
        wdata_q <= '0;
        streak  <= '0;
      end
      if (timeout_hit)
        rdata_q <= 32'hDEADBEEF;
      else if (state == BUSY && bus.mem_ready && !we_q)
        rdata_q <= bus.mem_rdata;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Counter sits at zero outside BUSY, so every access starts a fresh count.
  assign timeout_hit = (state == BUSY) && !bus.mem_ready && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == BUSY) to_cnt <= to_cnt + TO_W'(1);
      else               to_cnt <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
  assign unused_cfg  = (TIMEOUT > 0) ^ (TO_W > 0);
`endif

  assign bus.mem_sel   = sel_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and random
// traffic compared against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_pass = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_STREAK(MAX_STREAK), .STREAK_W(3), .TIMEOUT(TIMEOUT), .TO_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_cyc;
    bit          exp_sel;
    bit          exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    if (v.is_data) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      bus.if_req = 1'b0;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr; bus.d_req = 1'b0;
    end
    @(posedge clk); #1;
    for (int w = 0; w < v.wait_cyc; w++) begin
      @(negedge clk);
      check1("vec_wait_req", bus.mem_req, 1'b1);
      check1("vec_wait_sel", bus.mem_sel, v.exp_sel);
      check32("vec_wait_addr", bus.mem_addr, v.addr);
      check1("vec_wait_noack", bus.if_ack | bus.d_ack, 1'b0);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = v.rdata;
    @(negedge clk);
    check1("vec_req", bus.mem_req, 1'b1);
    check1("vec_sel", bus.mem_sel, v.exp_sel);
    check1("vec_we", bus.mem_we, v.exp_we);
    check32("vec_addr", bus.mem_addr, v.addr);
    check32("vec_wdata", bus.mem_wdata, v.exp_wdata);
    check1("vec_noack", bus.if_ack | bus.d_ack, 1'b0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check1("vec_if_ack", bus.if_ack, !v.exp_sel);
    check1("vec_d_ack", bus.d_ack, v.exp_sel);
    check1("vec_req_low", bus.mem_req, 1'b0);
    check32("vec_rdata", bus.rdata, v.exp_rdata);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
  endtask

  // ---------------- random traffic: drivers ----------------
  bit if_done, d_done, mem_active, rand_on;
  int mem_wait;

  always @(negedge clk) begin
    if (bus.if_ack) if_done = 1'b1;
    if (bus.d_ack)  d_done  = 1'b1;
  end

  task automatic new_fetch();
    bus.if_req = 1'b1; bus.if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
    bus.d_addr = $urandom & 32'hFFFF_FFFC; bus.d_wdata = $urandom;
  endtask

  task automatic req_step(input bit allow_new);
    if (if_done) begin
      if_done = 1'b0;
      if (allow_new && $urandom_range(0, 1) == 1) new_fetch(); else bus.if_req = 1'b0;
    end else if (allow_new && !bus.if_req && $urandom_range(0, 3) == 0) new_fetch();
    if (d_done) begin
      d_done = 1'b0;
      if (allow_new && $urandom_range(0, 1) == 1) new_data(); else bus.d_req = 1'b0;
    end else if (allow_new && !bus.d_req && $urandom_range(0, 2) == 0) new_data();
  endtask

  task automatic mem_step();
    if (bus.mem_ready) bus.mem_ready = 1'b0;
    else if (bus.mem_req) begin
      if (!mem_active) begin mem_active = 1'b1; mem_wait = $urandom_range(0, 3); end
      if (mem_wait == 0) begin
        bus.mem_ready = 1'b1; bus.mem_rdata = $urandom; mem_active = 1'b0;
      end else mem_wait--;
    end
  endtask

  // ---------------- random traffic: transaction-level model ----------------
  typedef enum int {M_FREE, M_WAIT, M_BUSY, M_DONE} mmode_t;
  mmode_t      m_mode;
  bit          m_port;      // 1 = data owns the port
  bit          m_we;
  bit          m_ack_due;
  int          m_passed;    // data grants made while a fetch kept waiting
  logic [31:0] m_addr, m_wdata, m_ret, m_rdata;

  always @(negedge clk) if (rand_on) begin
    case (m_mode)
      M_WAIT: begin
        check1("rnd_grant_req", bus.mem_req, 1'b1);
        check1("rnd_grant_sel", bus.mem_sel, m_port);
        check32("rnd_grant_addr", bus.mem_addr, m_addr);
        check1("rnd_grant_we", bus.mem_we, m_we);
        check32("rnd_grant_wdata", bus.mem_wdata, m_wdata);
        m_mode = M_BUSY;
      end
      M_BUSY: begin
        if (m_ack_due) begin
          check1("rnd_if_ack", bus.if_ack, !m_port);
          check1("rnd_d_ack", bus.d_ack, m_port);
          check1("rnd_req_low", bus.mem_req, 1'b0);
          if (!m_we) m_rdata = m_ret;
          check32("rnd_rdata", bus.rdata, m_rdata);
          m_ack_due = 1'b0;
          m_mode = M_DONE;
        end else begin
          check1("rnd_hold_req", bus.mem_req, 1'b1);
          check1("rnd_hold_sel", bus.mem_sel, m_port);
          check32("rnd_hold_addr", bus.mem_addr, m_addr);
          check1("rnd_hold_noack", bus.if_ack | bus.d_ack, 1'b0);
        end
      end
      M_DONE: begin
        check1("rnd_idle_req", bus.mem_req, 1'b0);
        check1("rnd_idle_noack", bus.if_ack | bus.d_ack, 1'b0);
        m_mode = M_FREE;
      end
      default: begin
        check1("rnd_free_req", bus.mem_req, 1'b0);
        check1("rnd_free_noack", bus.if_ack | bus.d_ack, 1'b0);
      end
    endcase
    if (m_mode == M_BUSY && !m_ack_due && bus.mem_ready) begin
      m_ack_due = 1'b1; m_ret = bus.mem_rdata;
    end
    if (m_mode == M_FREE && (bus.if_req || bus.d_req)) begin
      m_port = bus.d_req && !(bus.if_req && m_passed >= MAX_STREAK);
      if (m_port) begin
        m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata;
        m_passed = bus.if_req ? ((m_passed + 1 > MAX_STREAK) ? MAX_STREAK : m_passed + 1) : 0;
      end else begin
        m_addr = bus.if_addr; m_we = 1'b0; m_wdata = 32'h0;
        m_passed = 0;
      end
      m_mode = M_WAIT;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit drained;
    int busy_cnt;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    rand_on = 1'b0; if_done = 1'b0; d_done = 1'b0; mem_active = 1'b0; mem_wait = 0;
    busy_cnt = 0;

    vecs[0] = '{1'b0, 1'b0, 32'h00400000, 32'h0,        32'h8C080004, 0, 1'b0, 1'b0, 32'h0,        32'h8C080004};
    vecs[1] = '{1'b1, 1'b0, 32'h10010004, 32'h0,        32'hCAFEF00D, 0, 1'b1, 1'b0, 32'h0,        32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b1, 32'h10010008, 32'hA5A5A5A5, 32'h11111111, 1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 32'h00400004, 32'h0,        32'h2402000A, 5, 1'b0, 1'b0, 32'h0,        32'h2402000A};
    vecs[4] = '{1'b1, 1'b0, 32'h1001000C, 32'h0,        32'hFFFFFFFF, 2, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFF};
    vecs[5] = '{1'b0, 1'b0, 32'h00400008, 32'h0,        32'h00000001, 0, 1'b0, 1'b0, 32'h0,        32'h00000001};

    // Reset state
    #2;
    check1("rst_mem_req", bus.mem_req, 1'b0);
    check1("rst_mem_sel", bus.mem_sel, 1'b0);
    check1("rst_mem_we", bus.mem_we, 1'b0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0);
    check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check32("rst_rdata", bus.rdata, 32'h0);
    check1("rst_acks", bus.if_ack | bus.d_ack, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check32("rst_state", 32'(dbg_state), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests with an empty streak: the store goes first, fetch follows
    bus.if_req = 1'b1; bus.if_addr = 32'h00400000;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10010000; bus.d_wdata = 32'h12345678;
    @(posedge clk); #1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    check1("sim_d_sel", bus.mem_sel, 1'b1);
    check1("sim_d_we", bus.mem_we, 1'b1);
    check32("sim_d_addr", bus.mem_addr, 32'h10010000);
    check32("sim_d_wdata", bus.mem_wdata, 32'h12345678);
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    check1("sim_d_ack", bus.d_ack, 1'b1);
    check1("sim_if_noack", bus.if_ack, 1'b0);
    check32("sim_store_rdata", bus.rdata, 32'h00000001);
    @(posedge clk); #1; bus.d_req = 1'b0;
    @(negedge clk);
    check1("sim_gap_req", bus.mem_req, 1'b0);
    @(posedge clk); #1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h8C080008;
    @(negedge clk);
    check1("sim_f_req", bus.mem_req, 1'b1);
    check1("sim_f_sel", bus.mem_sel, 1'b0);
    check1("sim_f_we", bus.mem_we, 1'b0);
    check32("sim_f_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    check1("sim_if_ack", bus.if_ack, 1'b1);
    check32("sim_f_rdata", bus.rdata, 32'h8C080008);
    @(posedge clk); #1; bus.if_req = 1'b0;

    // Both ports requesting continuously: four data grants, then one fetch, repeating
    bus.if_req = 1'b1; bus.if_addr = 32'h00400010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10010010;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1000 + k;
      @(negedge clk);
      check1("stv_req", bus.mem_req, 1'b1);
      check1("stv_sel", bus.mem_sel, (k % 5) != 4);
      @(posedge clk); #1; bus.mem_ready = 1'b0;
      @(negedge clk);
      check1("stv_d_ack", bus.d_ack, (k % 5) != 4);
      check1("stv_if_ack", bus.if_ack, (k % 5) == 4);
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after TIMEOUT busy cycles with the poison value
    bus.if_req = 1'b1; bus.if_addr = 32'h00400080; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.mem_req) break;
      busy_cnt++;
    end
    check32("to_busy_cycles", 32'(busy_cnt), 32'(TIMEOUT));
    check1("to_if_ack", bus.if_ack, 1'b1);
    check32("to_rdata", bus.rdata, 32'hDEADBEEF);
    check1("to_err", bus.err, 1'b1);
    @(posedge clk); #1; bus.if_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("to_err_sticky", bus.err, 1'b1);
    @(posedge clk); #1;
`endif

    // Random traffic from a clean reset
    @(negedge clk); rst_n = 1'b0;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    if_done = 1'b0; d_done = 1'b0; mem_active = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_mode = M_FREE; m_passed = 0; m_rdata = 32'h0; m_ack_due = 1'b0;
    rand_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1; req_step(1'b1); mem_step();
    end
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      @(posedge clk); #1; req_step(1'b0); mem_step();
      drained = !bus.if_req && !bus.d_req;
    end
    check1("rnd_drain", drained, 1'b1);
    repeat (3) @(posedge clk);
    #1; rand_on = 1'b0;

    // Asynchronous reset in the middle of a store
    bus.mem_ready = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10010040; bus.d_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    @(negedge clk);
    check1("mrst_busy", bus.mem_req, 1'b1);
    #2; rst_n = 1'b0;
    #1;
    check1("mrst_req", bus.mem_req, 1'b0);
    check1("mrst_sel", bus.mem_sel, 1'b0);
    check1("mrst_we", bus.mem_we, 1'b0);
    check32("mrst_addr", bus.mem_addr, 32'h0);
    check32("mrst_wdata", bus.mem_wdata, 32'h0);
    check1("mrst_acks", bus.if_ack | bus.d_ack, 1'b0);
    check1("mrst_err", bus.err, 1'b0);
    check32("mrst_state", 32'(dbg_state), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    check1("mrst_rel_noack", bus.if_ack | bus.d_ack, 1'b0);
    @(posedge clk); #1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77777777;
    @(negedge clk);
    check1("mrst_regrant_req", bus.mem_req, 1'b1);
    check1("mrst_regrant_sel", bus.mem_sel, 1'b1);
    check32("mrst_regrant_addr", bus.mem_addr, 32'h10010040);
    check1("mrst_no_stale_ack", bus.d_ack, 1'b0);
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    check1("mrst_d_ack", bus.d_ack, 1'b1);
    check32("mrst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1; bus.d_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
